button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//  Conditions the raw active-low push buttons (btnUp/btnDown/btnLeft/btnRight) before buttonModule and the top-level run/reset FSM.
//  Per button: 2-flop synchroniser, counter-based debounce, press/release edge pulses.
//  Sticky press/release event flags are readable over the CPU data bus. Any flag read through the bus clears that flag.
//  Sits between board pins and buttonModule/bus; runs on the CPU clock domain.
// PARAMETERS
//  NUM_BTNS       4        number of buttons; bit0=up, 1=down, 2=left, 3=right
//  DEBOUNCE_CYC   1000000  cycles input must be stable before accepted (sim: 8)
//  CNT_W          20       counter width; must satisfy 2**CNT_W > DEBOUNCE_CYC
// PORTS
//  clk            in   1         CPU clock, all logic rising-edge
//  reset          in   1         synchronous, active-high
//  btn_n          in   NUM_BTNS  raw pins, active-low (0 = pressed), asynchronous
//  ren            in   1         bus read strobe for this block
//  addr           in   2         register select (data_addr[3:2])
//  data_out       out  32        registered read data
//  level          out  NUM_BTNS  debounced state, active-high (1 = held)
//  press_pulse    out  NUM_BTNS  1-cycle pulse on accepted press
//  release_pulse  out  NUM_BTNS  1-cycle pulse on accepted release
// BEHAVIOUR
//  Reset: sync flops = all 1 (released); level, pulses, counters, sticky flags, data_out = 0.
//  Sync: btn_n -> s1 -> s2, then inverted to s_act. Input-to-counter latency is 2 cycles.
//  Per-button debounce FSM, 2 states:
//    IDLE: s_act == level. Counter held at 0.
//    COUNT: s_act != level. Counter increments each cycle.
//      If s_act returns to level before terminal: counter cleared, back to IDLE (glitch rejected).
//      At counter == DEBOUNCE_CYC-1: level toggles next cycle, counter -> 0, back to IDLE.
//  Pulses: press_pulse = 1 in the cycle level goes 0->1. release_pulse = 1 in the cycle level goes 1->0. Both are registered.
//  Sticky flags: press_flag[i] is set by press_pulse[i]; rel_flag[i] is set by release_pulse[i].
//  Register map (read-only; data_out upper bits zero):
//    addr 0: {level}           no side effect
//    addr 1: {press_flag}      clear-on-read
//    addr 2: {rel_flag}        clear-on-read
//    addr 3: 32'h4254_4E00 | NUM_BTNS   (ID word)
//  Read timing: ren sampled at edge N, data_out valid after edge N; the clear takes effect at the same edge N.
//    data_out holds until the next ren. Writes are ignored (no wen port).
//  Simultaneous set and clear-on-read of the same flag in one cycle: set wins.
//    The flag stays 1, and the returned data shows the pre-edge value.
//  Buttons are independent; simultaneous events on several buttons are all captured.
//  Reset mid-count: counter is discarded and level returns to 0.
//    A button held through reset is re-accepted as a press DEBOUNCE_CYC+2 cycles after reset falls.
//  Counter never wraps: terminal compare precedes overflow; CNT_W check is an elaboration assertion.
// STRUCTURE
//  Shared package btn_pkg.vh: BTN_UP/DOWN/LEFT/RIGHT indices, REG_LEVEL/PRESS/REL/ID addresses, BTN_ID constant.
//  Sub-module debounce_cell (one button: sync, counter, level, pulses), instantiated NUM_BTNS times via generate.
//  Top of block holds the sticky flags and the read mux.
// TESTING (DEBOUNCE_CYC=8)
//  1. Reset: reset=1 for 2 cycles -> level=0, data_out=0. Read addr 3 -> 32'h4254_4E04.
//  2. Clean press: btn_n[0]=0 held -> level[0]=1 and press_pulse[0]=1 exactly 10 cycles after the change.
//     Read addr1 -> 1. Read addr1 again -> 0.
//  3. Bounce: btn_n[2] toggles every 3 cycles for 30 cycles then stays 1 -> level[2] never rises, no pulses, addr1=0.
//  4. Set-vs-clear race: press_pulse[1] coincides with ren at addr1 -> data_out bit1=0, next read of addr1 returns bit1=1.
//  5. Multi-button: btn_n=4'b0000 together -> one press_pulse=4'hF cycle. Release all -> release_pulse=4'hF, addr2=0xF.
//  6. Reset mid-count: assert reset at count 5 with button held -> no pulse.
//     After reset falls, press_pulse[0] rises 10 cycles later.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Shared constants for the push-button conditioning block: button indices,
// register addresses, the ID word and the per-button debounce FSM states.
package button_debounce_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  localparam logic [1:0] REG_LEVEL = 2'd0;
  localparam logic [1:0] REG_PRESS = 2'd1;
  localparam logic [1:0] REG_REL   = 2'd2;
  localparam logic [1:0] REG_ID    = 2'd3;

  localparam logic [31:0] BTN_ID_BASE = 32'h4254_4E00;

  typedef enum logic {
    ST_IDLE,
    ST_COUNT
  } db_state_e;

  function automatic logic [31:0] btn_id(input int num_btns);
    return BTN_ID_BASE | 32'(num_btns);
  endfunction

endpackage

// File: rtl/button_debounce_cell.sv
// One button: 2-flop synchroniser, counter debounce FSM, registered level
// and single-cycle press/release pulses.
module button_debounce_cell
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CNT_W        = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  if (64'(DEBOUNCE_CYC) >= (64'd1 << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too small for DEBOUNCE_CYC");
  end

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYC - 1);

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s1_d, s2_q, s2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             s_act;

  // NOTE: sequential state uses non-blocking assignments only; all next-state
  // logic lives in the always_comb below so each flop has a single driver.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchroniser resets to the pin's released level so no false press follows reset.
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign s_act = ~s2_q;

  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    s1_d    = btn_n;
    s2_d    = s1_q;
    state_d = ST_IDLE;
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_COUNT: begin
        // A mismatch that disappears before terminal falls through to IDLE with a cleared counter.
        if (s_act != level_q) begin
          if (cnt_q == CNT_TERM) begin
            level_d = s_act;
            press_d = s_act;
            rel_d   = ~s_act;
          end else begin
            state_d = ST_COUNT;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

endmodule

// File: rtl/button_debounce.sv
// Debounces NUM_BTNS active-low buttons and exposes level, sticky
// press/release flags (clear-on-read) and an ID word on the CPU bus.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int NUM_BTNS     = 4,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CNT_W        = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_n,
  input  logic                ren,
  input  logic [1:0]          addr,
  output logic [31:0]         data_out,
  output logic [NUM_BTNS-1:0] level,
  output logic [NUM_BTNS-1:0] press_pulse,
  output logic [NUM_BTNS-1:0] release_pulse
);

  logic [NUM_BTNS-1:0] press_flag_q, press_flag_d;
  logic [NUM_BTNS-1:0] rel_flag_q, rel_flag_d;
  logic [NUM_BTNS-1:0] press_clr, rel_clr;
  logic [31:0]         data_out_q, data_out_d;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_cell
    button_debounce_cell #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W)
    ) u_cell (
      .clk          (clk),
      .reset        (reset),
      .btn_n        (btn_n[i]),
      .level        (level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      press_flag_q <= '0;
      rel_flag_q   <= '0;
      data_out_q   <= '0;
    end else begin
      press_flag_q <= press_flag_d;
      rel_flag_q   <= rel_flag_d;
      data_out_q   <= data_out_d;
    end
  end

  always_comb begin
    press_clr  = '0;
    rel_clr    = '0;
    data_out_d = data_out_q;
    if (ren) begin
      case (addr)
        REG_LEVEL: data_out_d = 32'(level);
        REG_PRESS: begin
          data_out_d = 32'(press_flag_q);
          press_clr  = '1;
        end
        REG_REL: begin
          data_out_d = 32'(rel_flag_q);
          rel_clr    = '1;
        end
        REG_ID:    data_out_d = btn_id(NUM_BTNS);
        default:   data_out_d = data_out_q;
      endcase
    end
    // Set is OR-ed in after the clear so a pulse coinciding with a read is not lost.
    press_flag_d = (press_flag_q & ~press_clr) | press_pulse;
    rel_flag_d   = (rel_flag_q & ~rel_clr) | release_pulse;
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with DEBOUNCE_CYC=8: bus reads go
// through an expected-value queue, pulse timing is checked against fixed latencies.
module tb_button_debounce;
  import button_debounce_pkg::*;

  localparam int NB     = 4;
  localparam int DB_CYC = 8;
  localparam int LAT    = DB_CYC + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_n;
  logic          ren;
  logic [1:0]    addr;
  logic [31:0]   data_out;
  logic [NB-1:0] level;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] release_pulse;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  button_debounce #(
    .NUM_BTNS    (NB),
    .DEBOUNCE_CYC(DB_CYC),
    .CNT_W       (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_n        (btn_n),
    .ren          (ren),
    .addr         (addr),
    .data_out     (data_out),
    .level        (level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.val = exp;
    sb_q.push_back(e);
    addr = a;
    ren  = 1'b1;
    tick();
    ren  = 1'b0;
    e = sb_q.pop_front();
    check(e.tag, data_out, e.val);
  endtask

  // Counts edges from the stimulus change until the first pulse, bounded.
  task automatic wait_pulse(input string tag, input bit rel, input logic [NB-1:0] exp_mask);
    int            n = 0;
    logic [NB-1:0] p = '0;
    while (n < 3 * LAT && p == '0) begin
      tick();
      n++;
      p = rel ? release_pulse : press_pulse;
    end
    check({tag, "_lat"}, 32'(n), 32'(LAT));
    check({tag, "_mask"}, 32'(p), 32'(exp_mask));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] bad;
    reset = 1'b1;
    btn_n = '1;
    ren   = 1'b0;
    addr  = 2'd0;

    // Reset state and ID word
    tick();
    tick();
    check("rst_level", 32'(level), 32'h0);
    check("rst_data", data_out, 32'h0);
    check("rst_press", 32'(press_pulse), 32'h0);
    reset = 1'b0;
    tick();
    bus_read("id_word", REG_ID, 32'h4254_4E04);
    tick();
    check("data_hold", data_out, 32'h4254_4E04);

    // Clean press and release on the up button
    btn_n[BTN_UP] = 1'b0;
    wait_pulse("up_press", 1'b0, 4'b0001);
    check("up_level", 32'(level), 32'h1);
    tick();
    check("up_pulse_1cyc", 32'(press_pulse), 32'h0);
    bus_read("up_press_flag", REG_PRESS, 32'h1);
    bus_read("up_press_cleared", REG_PRESS, 32'h0);
    bus_read("up_level_reg", REG_LEVEL, 32'h1);
    btn_n[BTN_UP] = 1'b1;
    wait_pulse("up_release", 1'b1, 4'b0001);
    check("up_level_low", 32'(level), 32'h0);
    tick();
    bus_read("up_rel_flag", REG_REL, 32'h1);

    // Bouncing left button is rejected
    bad = '0;
    for (int c = 0; c < 30; c++) begin
      if (c % 3 == 0) btn_n[BTN_LEFT] = ~btn_n[BTN_LEFT];
      tick();
      bad |= press_pulse | release_pulse | level;
    end
    btn_n[BTN_LEFT] = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      bad |= press_pulse | release_pulse | level;
    end
    check("bounce_quiet", 32'(bad), 32'h0);
    bus_read("bounce_press_flag", REG_PRESS, 32'h0);
    bus_read("bounce_rel_flag", REG_REL, 32'h0);

    // Set-versus-clear race on the down button
    btn_n[BTN_DOWN] = 1'b0;
    bad = '0;
    for (int c = 0; c < LAT - 1; c++) begin
      tick();
      bad |= press_pulse;
    end
    check("race_early", 32'(bad), 32'h0);
    tick();
    check("race_pulse", 32'(press_pulse), 32'h2);
    bus_read("race_read_pre", REG_PRESS, 32'h0);
    bus_read("race_read_set", REG_PRESS, 32'h2);
    bus_read("race_read_clr", REG_PRESS, 32'h0);
    btn_n[BTN_DOWN] = 1'b1;
    wait_pulse("down_release", 1'b1, 4'b0010);
    tick();
    bus_read("down_rel_flag", REG_REL, 32'h2);

    // All buttons together
    btn_n = 4'b0000;
    wait_pulse("all_press", 1'b0, 4'hF);
    check("all_level", 32'(level), 32'hF);
    tick();
    bus_read("all_press_flag", REG_PRESS, 32'hF);
    btn_n = 4'b1111;
    wait_pulse("all_release", 1'b1, 4'hF);
    tick();
    bus_read("all_rel_flag", REG_REL, 32'hF);
    bus_read("all_level_reg", REG_LEVEL, 32'h0);
    bus_read("id_again", REG_ID, 32'h4254_4E04);

    // Reset in the middle of a count, button held throughout
    btn_n[BTN_UP] = 1'b0;
    bad = '0;
    repeat (7) begin
      tick();
      bad |= press_pulse;
    end
    reset = 1'b1;
    tick();
    bad |= press_pulse;
    tick();
    bad |= press_pulse;
    check("midrst_no_pulse", 32'(bad), 32'h0);
    check("midrst_level", 32'(level), 32'h0);
    check("midrst_data", data_out, 32'h0);
    reset = 1'b0;
    wait_pulse("midrst_press", 1'b0, 4'b0001);
    check("midrst_level_up", 32'(level), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
